// File: rtl/mem_map_pkg.sv
// -----------------------------------------------------------------------------
// mem_map_pkg
// Shared types and constants for the S100 Z80 SBC memory-map decoder and
// its wait-state counter.
//   access_state_e : bus access FSM states (IDLE, ACTIVE)
//   region_e       : decoded memory region (REG_NONE, REG_ROM, REG_RAM)
//   WS_W           : width of wait-state counters (0..15 wait clocks)
// -----------------------------------------------------------------------------
package mem_map_pkg;

    localparam int WS_W = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } access_state_e;

    typedef enum logic [1:0] {
        REG_NONE = 2'd0,
        REG_ROM  = 2'd1,
        REG_RAM  = 2'd2
    } region_e;

endpackage

// File: rtl/mem_wait_counter.sv
// -----------------------------------------------------------------------------
// mem_wait_counter
// Loadable down-counter that produces a registered wait request. Intended to
// be shared by memory and (later) I/O decoders.
// Ports:
//   clock    in   system clock
//   reset_n  in   asynchronous active-low reset
//   active   in   bus strobe of the current access; low clears the counter
//   load     in   first clock of an access; loads load_val
//   load_val in   number of wait clocks for this access (0 = no wait)
//   wait_req out  registered; high while the count is non-zero and active
// -----------------------------------------------------------------------------
module mem_wait_counter
    import mem_map_pkg::*;
(
    input  logic            clock,
    input  logic            reset_n,
    input  logic            active,
    input  logic            load,
    input  logic [WS_W-1:0] load_val,
    output logic            wait_req
);

    logic [WS_W-1:0] cnt_r;
    logic [WS_W-1:0] cnt_next_s;
    logic            zero_s;
    logic            wait_req_r;

    // Next count: clear when the strobe drops, load at access start, else count down to zero
    always_comb begin
        zero_s     = (cnt_r == {WS_W{1'b0}});
        cnt_next_s = cnt_r;
        if (!active) begin
            cnt_next_s = {WS_W{1'b0}};
        end else if (load) begin
            cnt_next_s = load_val;
        end else if (!zero_s) begin
            cnt_next_s = cnt_r - {{(WS_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_next_s = {WS_W{1'b0}};
        end
    end

    // Counter and registered wait request (request follows the updated count)
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r      <= {WS_W{1'b0}};
            wait_req_r <= 1'b0;
        end else begin
            cnt_r      <= cnt_next_s;
            wait_req_r <= (cnt_next_s != {WS_W{1'b0}});
        end
    end

    assign wait_req = wait_req_r;

endmodule

// File: rtl/mem_map_decoder.sv
// -----------------------------------------------------------------------------
// mem_map_decoder
// Memory-map decoder for the S100 Z80 FPGA SBC. Decodes CPU strobes into
// registered ROM/RAM chip selects, inserts per-region wait states and keeps a
// boot overlay (ROM answers all reads after reset until the first read that
// actually falls inside the ROM window).
// Optional feature: define MEM_BANK_EN to add a RAM bank register.
// Ports:
//   clock, reset_n        clock, asynchronous active-low reset
//   address               CPU address (ADDR_W bits)
//   memread, memwrite     active-high memory strobes
//   rom_cs, ram_cs        registered chip selects (one-hot or idle)
//   wait_req              registered wait request to CPU WAIT logic
//   boot_active           high while the boot overlay is in force
//   bank_wr, bank_data    (MEM_BANK_EN) bank register load strobe / value
//   ram_bank              (MEM_BANK_EN) bank latched at access start
// -----------------------------------------------------------------------------
module mem_map_decoder
    import mem_map_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int ROM_BASE = 'hF000,
    parameter int ROM_SIZE = 'h1000,
    parameter int ROM_WS   = 2,
    parameter int RAM_WS   = 0,
    parameter int BANK_W   = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              memread,
    input  logic              memwrite,
    output logic              rom_cs,
    output logic              ram_cs,
    output logic              wait_req,
    output logic              boot_active
`ifdef MEM_BANK_EN
    ,
    input  logic              bank_wr,
    input  logic [BANK_W-1:0] bank_data,
    output logic [BANK_W-1:0] ram_bank
`endif
);

    localparam logic [ADDR_W-1:0] ROM_MASK_C = ~ADDR_W'(ROM_SIZE - 1);
    localparam logic [ADDR_W-1:0] ROM_BASE_C = ADDR_W'(ROM_BASE);
    localparam logic [WS_W-1:0]   ROM_WS_C   = WS_W'(ROM_WS);
    localparam logic [WS_W-1:0]   RAM_WS_C   = WS_W'(RAM_WS);

    // Elaboration-time parameter sanity checks
    if ((ROM_SIZE <= 0) || ((ROM_SIZE & (ROM_SIZE - 1)) != 0) || (ROM_SIZE > (2 ** ADDR_W)))
        begin : g_bad_rom_size
            $error("mem_map_decoder: ROM_SIZE must be a power of two <= 2**ADDR_W");
        end
    if ((ROM_BASE & (ROM_SIZE - 1)) != 0) begin : g_bad_rom_base
        $error("mem_map_decoder: ROM_BASE must be aligned to ROM_SIZE");
    end
    if ((ROM_WS < 0) || (ROM_WS > 15) || (RAM_WS < 0) || (RAM_WS > 15) || (BANK_W < 1))
        begin : g_bad_ws
            $error("mem_map_decoder: wait states must be 0..15 and BANK_W >= 1");
        end

    access_state_e   state_r;
    region_e         region_r;
    region_e         region_s;
    logic            access_prev_r;
    logic            rom_cs_r;
    logic            ram_cs_r;
    logic            boot_r;
    logic            access_s;
    logic            access_start_s;
    logic            rd_only_s;
    logic            in_rom_s;
    logic [WS_W-1:0] ws_load_s;

    // Strobe edge detect and region decode for the access being started
    always_comb begin
        access_s       = memread | memwrite;
        access_start_s = access_s & ~access_prev_r;
        // Simultaneous read and write strobes are treated as a write
        rd_only_s      = memread & ~memwrite;
        in_rom_s       = ((address & ROM_MASK_C) == ROM_BASE_C);
        if (rd_only_s && (in_rom_s || boot_r)) begin
            region_s  = REG_ROM;
            ws_load_s = ROM_WS_C;
        end else begin
            region_s  = REG_RAM;
            ws_load_s = RAM_WS_C;
        end
    end

    // Access FSM with registered chip selects and boot overlay
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= IDLE;
            region_r      <= REG_NONE;
            access_prev_r <= 1'b0;
            rom_cs_r      <= 1'b0;
            ram_cs_r      <= 1'b0;
            boot_r        <= 1'b1;
        end else begin
            access_prev_r <= access_s;
            // First read into the ROM window ends the overlay; that read is still ROM
            if (access_start_s && rd_only_s && in_rom_s) begin
                boot_r <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (access_start_s) begin
                        state_r  <= ACTIVE;
                        region_r <= region_s;
                        rom_cs_r <= (region_s == REG_ROM);
                        ram_cs_r <= (region_s == REG_RAM);
                    end else begin
                        region_r <= REG_NONE;
                        rom_cs_r <= 1'b0;
                        ram_cs_r <= 1'b0;
                    end
                end
                ACTIVE: begin
                    // Decode is held for the whole access; address changes are ignored
                    if (!access_s) begin
                        state_r  <= IDLE;
                        region_r <= REG_NONE;
                        rom_cs_r <= 1'b0;
                        ram_cs_r <= 1'b0;
                    end else begin
                        rom_cs_r <= (region_r == REG_ROM);
                        ram_cs_r <= (region_r == REG_RAM);
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    region_r <= REG_NONE;
                    rom_cs_r <= 1'b0;
                    ram_cs_r <= 1'b0;
                end
            endcase
        end
    end

    mem_wait_counter u_wait_counter (
        .clock    (clock),
        .reset_n  (reset_n),
        .active   (access_s),
        .load     (access_start_s),
        .load_val (ws_load_s),
        .wait_req (wait_req)
    );

`ifdef MEM_BANK_EN
    logic [BANK_W-1:0] bank_r;
    logic [BANK_W-1:0] ram_bank_r;

    // Bank register; the value in use is sampled at access start so a load
    // during an access only affects the following access
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bank_r     <= {BANK_W{1'b0}};
            ram_bank_r <= {BANK_W{1'b0}};
        end else begin
            if (access_start_s) begin
                ram_bank_r <= bank_r;
            end
            if (bank_wr) begin
                bank_r <= bank_data;
            end
        end
    end

    assign ram_bank = ram_bank_r;
`endif

    assign rom_cs      = rom_cs_r;
    assign ram_cs      = ram_cs_r;
    assign boot_active = boot_r;

endmodule

// File: tb/tb_mem_map_decoder.sv
// -----------------------------------------------------------------------------
// tb_mem_map_decoder
// Self-checking bench for mem_map_decoder: directed scenarios with literal
// expectations, then randomized strobes/addresses/resets compared every
// cycle against an access-level reference model.
// -----------------------------------------------------------------------------
module tb_mem_map_decoder;

    localparam int ADDR_W   = 16;
    localparam int ROM_BASE = 'hF000;
    localparam int ROM_SIZE = 'h1000;
    localparam int ROM_WS   = 2;
    localparam int RAM_WS   = 0;
    localparam int BANK_W   = 2;

    logic              clock;
    logic              reset_n;
    logic [ADDR_W-1:0] address;
    logic              memread;
    logic              memwrite;
    logic              rom_cs;
    logic              ram_cs;
    logic              wait_req;
    logic              boot_active;
`ifdef MEM_BANK_EN
    logic              bank_wr;
    logic [BANK_W-1:0] bank_data;
    logic [BANK_W-1:0] ram_bank;
`endif

    int tests;
    int fails;

    // Reference model state (access-level view)
    bit m_prev;
    bit m_boot;
    bit m_is_rom;
    bit m_rom;
    bit m_ram;
    bit m_wait;
    int m_n;
    int m_bank_reg;
    int m_bank;

    mem_map_decoder #(
        .ADDR_W   (ADDR_W),
        .ROM_BASE (ROM_BASE),
        .ROM_SIZE (ROM_SIZE),
        .ROM_WS   (ROM_WS),
        .RAM_WS   (RAM_WS),
        .BANK_W   (BANK_W)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .address     (address),
        .memread     (memread),
        .memwrite    (memwrite),
        .rom_cs      (rom_cs),
        .ram_cs      (ram_cs),
        .wait_req    (wait_req),
        .boot_active (boot_active)
`ifdef MEM_BANK_EN
        ,
        .bank_wr     (bank_wr),
        .bank_data   (bank_data),
        .ram_bank    (ram_bank)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev     = 1'b0;
        m_boot     = 1'b1;
        m_is_rom   = 1'b0;
        m_rom      = 1'b0;
        m_ram      = 1'b0;
        m_wait     = 1'b0;
        m_n        = 0;
        m_bank_reg = 0;
        m_bank     = 0;
    endtask

    // Outputs after a rising edge, from the strobes seen at that edge
    task automatic model_step();
        bit acc;
        bit rd_only;
        bit inrom;
        int a;
        if (!reset_n) begin
            model_reset();
            return;
        end
        a       = int'(address);
        acc     = memread || memwrite;
        rd_only = memread && !memwrite;
        inrom   = (a >= ROM_BASE) && (a < ROM_BASE + ROM_SIZE);
        if (acc && !m_prev) begin
            m_is_rom = rd_only && (inrom || m_boot);
            if (rd_only && inrom) m_boot = 1'b0;
            m_n    = 0;
            m_bank = m_bank_reg;
        end else if (acc) begin
            m_n++;
        end
        if (acc) begin
            m_rom  = m_is_rom;
            m_ram  = !m_is_rom;
            m_wait = m_n < (m_is_rom ? ROM_WS : RAM_WS);
        end else begin
            m_rom  = 1'b0;
            m_ram  = 1'b0;
            m_wait = 1'b0;
        end
        m_prev = acc;
`ifdef MEM_BANK_EN
        if (bank_wr) m_bank_reg = int'(bank_data);
`endif
    endtask

    task automatic compare();
        check("rom_cs", int'(rom_cs), int'(m_rom));
        check("ram_cs", int'(ram_cs), int'(m_ram));
        check("wait_req", int'(wait_req), int'(m_wait));
        check("boot_active", int'(boot_active), int'(m_boot));
`ifdef MEM_BANK_EN
        check("ram_bank", int'(ram_bank), m_bank);
`endif
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare();
    endtask

    task automatic drive(input bit rd, input bit wr, input int a);
        memread  = rd;
        memwrite = wr;
        address  = ADDR_W'(a);
    endtask

    task automatic end_access();
        drive(1'b0, 1'b0, 0);
        cycle();
    endtask

    task automatic async_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_rom_cs", int'(rom_cs), 0);
        check("rst_ram_cs", int'(ram_cs), 0);
        check("rst_wait_req", int'(wait_req), 0);
        check("rst_boot_active", int'(boot_active), 1);
        compare();
        drive(1'b0, 1'b0, 0);
        cycle();
        reset_n = 1'b1;
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        reset_n  = 1'b0;
        drive(1'b0, 1'b0, 0);
`ifdef MEM_BANK_EN
        bank_wr   = 1'b0;
        bank_data = '0;
`endif
        model_reset();
        @(negedge clock);
        async_reset();

        // Boot overlay: read 0000h answers from ROM with ROM wait states
        drive(1'b1, 1'b0, 'h0000);
        cycle(); check("boot_rd0_rom", int'(rom_cs), 1); check("boot_rd0_wait1", int'(wait_req), 1);
        cycle(); check("boot_rd0_wait2", int'(wait_req), 1);
        cycle(); check("boot_rd0_wait3", int'(wait_req), 0); check("boot_rd0_hold", int'(rom_cs), 1);
        end_access(); check("boot_rd0_end", int'(rom_cs), 0);
        // Read F000h: ROM, overlay exits
        drive(1'b1, 1'b0, 'hF000);
        cycle(); check("rdF000_rom", int'(rom_cs), 1); check("rdF000_boot", int'(boot_active), 0);
        cycle(); cycle(); end_access();
        // After boot exit, 0000h is RAM with no waits
        drive(1'b1, 1'b0, 'h0000);
        cycle(); check("rd0_ram", int'(ram_cs), 1); check("rd0_rom", int'(rom_cs), 0);
        check("rd0_wait", int'(wait_req), 0);
        cycle(); check("rd0_wait_b", int'(wait_req), 0);
        end_access();
        // F123h: exactly two wait clocks, address change mid-access ignored
        drive(1'b1, 1'b0, 'hF123);
        cycle(); check("rdF123_rom", int'(rom_cs), 1); check("rdF123_w1", int'(wait_req), 1);
        address = 16'h0100;
        cycle(); check("rdF123_w2", int'(wait_req), 1);
        cycle(); check("rdF123_w3", int'(wait_req), 0); check("rdF123_hold", int'(rom_cs), 1);
        end_access();
        // Write into ROM window lands in shadow RAM
        drive(1'b0, 1'b1, 'hF010);
        cycle(); check("wrF010_ram", int'(ram_cs), 1); check("wrF010_rom", int'(rom_cs), 0);
        check("wrF010_boot", int'(boot_active), 0);
        end_access();
        // Same write during boot, and read+write together, keep the overlay
        @(negedge clock);
        async_reset();
        drive(1'b0, 1'b1, 'hF010);
        cycle(); check("boot_wr_ram", int'(ram_cs), 1); check("boot_wr_boot", int'(boot_active), 1);
        end_access();
        drive(1'b1, 1'b1, 'hF000);
        cycle(); check("rdwr_ram", int'(ram_cs), 1); check("rdwr_boot", int'(boot_active), 1);
        end_access();
        // Reset during a ROM read with wait_req high
        drive(1'b1, 1'b0, 'hF123);
        cycle(); check("pre_rst_wait", int'(wait_req), 1);
        async_reset();
        drive(1'b1, 1'b0, 'h0000);
        cycle(); check("post_rst_rom", int'(rom_cs), 1); check("post_rst_boot", int'(boot_active), 1);
        end_access();
`ifdef MEM_BANK_EN
        drive(1'b1, 1'b0, 'hF000); cycle(); end_access();
        drive(1'b1, 1'b0, 'h1000);
        cycle();
        bank_wr = 1'b1; bank_data = 2'd2;
        cycle(); bank_wr = 1'b0;
        check("bank_held", int'(ram_bank), 0);
        end_access();
        drive(1'b1, 1'b0, 'h1000);
        cycle(); check("bank_next", int'(ram_bank), 2);
        end_access();
`endif

        // Randomized strobes, addresses, hold lengths, gaps and resets
        for (int i = 0; i < 400; i++) begin
            int sel;
            int a;
            int len;
            bit rd;
            bit wr;
            sel = int'($urandom_range(0, 5));
            case (sel)
                0: a = int'($urandom_range(0, 'hFFFF));
                1: a = ROM_BASE + int'($urandom_range(0, ROM_SIZE - 1));
                2: a = ROM_BASE;
                3: a = ROM_BASE - 1;
                4: a = 'hFFFF;
                default: a = 0;
            endcase
            rd  = ($urandom_range(0, 3) != 0);
            wr  = !rd || ($urandom_range(0, 7) == 0);
            len = int'($urandom_range(1, 6));
            if ($urandom_range(0, 39) == 0) begin
                @(negedge clock);
                async_reset();
            end
            drive(rd, wr, a);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 4) == 0) address = ADDR_W'($urandom_range(0, 'hFFFF));
`ifdef MEM_BANK_EN
                bank_wr   = ($urandom_range(0, 5) == 0);
                bank_data = BANK_W'($urandom_range(0, 3));
`endif
                cycle();
            end
`ifdef MEM_BANK_EN
            bank_wr = 1'b0;
`endif
            if ($urandom_range(0, 3) != 0) begin
                end_access();
            end
        end
        end_access();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
